stage5_writeback: RTL and testbench
===================================

Name: stage5_writeback

Overview:
- Final pipeline stage and the writer side of the register-file/forwarding interface that the decode stage reads.
- Accepts retiring instructions from the memory stage and selects the result source: ALU, load data or PC+4.
- Waits on the variable-latency data-memory load response, aligns and extends load data, and issues registered register-file writes plus forwarding data.
- Counts retired instructions.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  memory stage presents a retiring instruction
- rf_wen_i  in  1  instruction writes rd
- rd_addr_i  in  5  destination register
- wb_src_i  in  2  result source, type wb_src_e: WB_ALU=0, WB_LOAD=1, WB_PC4=2; value 3 is treated as WB_ALU
- alu_result_i  in  XLEN  ALU result; bits [1:0] give the load byte offset
- pc_incr_i  in  XLEN  PC+4 of the instruction
- ld_funct3_i  in  3  load type (LB=0, LH=1, LW=2, LBU=4, LHU=5)
- dmem_rvalid_i  in  1  load response valid
- dmem_rdata_i  in  XLEN  load response word
- dmem_err_i  in  1  load response error, qualified by dmem_rvalid_i
- stall_o  out  1  upstream must hold its current instruction
- wb_data_o  out  XLEN  register-file write data and forwarding value
- rd_addr_o  out  5  register-file write address
- rf_rw_en_o  out  1  register-file write enable
- load_fault_o  out  1  one-cycle pulse on an errored load response
- retire_o  out  1  one-cycle pulse per retired instruction
- instret_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset: every output register clears to 0, the state machine enters IDLE, and stall_o=0.
- Accept condition: accept = valid_i && !stall_o. stall_o = (state==WAIT_LD), decoded from the registered state only, with no combinational path from dmem_rvalid_i.
- IDLE with accept and wb_src other than LOAD:
  - Next cycle: rf_rw_en_o = rf_wen_i && (rd_addr_i!=0).
  - wb_data_o = alu_result_i for WB_ALU, pc_incr_i for WB_PC4.
  - rd_addr_o = rd_addr_i, retire_o=1. Latency is 1 cycle.
- IDLE with accept and wb_src=LOAD:
  - Latch rd, rf_wen, funct3 and offset alu_result_i[1:0], then go to WAIT_LD.
  - No write and no retire that cycle.
- WAIT_LD with dmem_rvalid_i=0: stay in WAIT_LD, outputs idle (rf_rw_en_o=0, retire_o=0).
- WAIT_LD with dmem_rvalid_i=1 and dmem_err_i=0, then next cycle:
  - Write the aligned/extended data, set retire_o=1, return to IDLE.
  - stall_o drops on that same next cycle, so a new instruction can be accepted there.
- WAIT_LD with dmem_rvalid_i=1 and dmem_err_i=1, then next cycle:
  - load_fault_o=1, no write, no retire, return to IDLE.
- Load alignment: shift dmem_rdata_i right by 8*offset, then extend.
  - LB: sign-extend bit 7. LBU: zero-extend byte.
  - LH: sign-extend bit 15. LHU: zero-extend halfword.
  - LW: full word. Any other funct3 is treated as LW.
  - Misalignment is already trapped upstream; offset is used as given.
- Non-write cycles: rf_rw_en_o=0, while wb_data_o and rd_addr_o hold their last values. rd=x0 never asserts rf_rw_en_o but still retires.
- dmem_rvalid_i in IDLE is ignored, and an assertion flags it. The response arrives at least 1 cycle after acceptance.
- instret_o increments by 1 in the same cycle retire_o is asserted and wraps from all-ones to 0.
- Asynchronous reset during WAIT_LD abandons the pending load; a later stray rvalid is ignored.

Decomposition:
- tcore_param holds:
  - wb_src_e enum.
  - Load funct3 localparams (LB, LH, LW, LBU, LHU).
  - wb_req_t struct bundling rf_wen, rd_addr, wb_src, alu_result, pc_incr, ld_funct3.
- One combinational sub-module, load_align: inputs data, offset and funct3; output the extended XLEN word.
- The state machine, output registers and counter live in stage5_writeback.

Test Plan:
- ALU op, rd=5, alu_result=0x1234_5678 accepted at cycle t -> cycle t+1: rf_rw_en_o=1, rd_addr_o=5, wb_data_o=0x1234_5678, retire_o=1, instret_o=1.
- LB, offset 3, rd=7; rvalid 3 cycles later with rdata=0x80FF_0000 -> stall_o=1 for exactly 3 cycles; next cycle wb_data_o=0xFFFF_FF80 written to x7; the following instruction is accepted that same cycle.
- LHU, offset 2, rdata=0x8001_ABCD -> 0x0000_8001. LH with the same inputs -> 0xFFFF_8001. Illegal funct3=3 -> 0x8001_ABCD.
- Load response with dmem_err_i=1 -> load_fault_o pulses 1 cycle, rf_rw_en_o=0, instret_o unchanged, state returns to IDLE.
- ALU op with rd=0 and rf_wen_i=1 -> rf_rw_en_o=0, retire_o=1. Preload instret to all-ones then retire -> instret_o=0.
- rst_ni deasserted mid WAIT_LD, then rvalid -> all outputs 0, stall_o=0, no write.

Source files
------------

// File: rtl/tcore_param.sv
// Shared types and constants for the writeback stage and its load aligner.
package tcore_param;

   // Result source selected for the register-file write; value 3 behaves as ALU
   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2
   } wb_src_e;

   // RISC-V load funct3 encodings
   localparam logic [2:0] LD_LB  = 3'd0;
   localparam logic [2:0] LD_LH  = 3'd1;
   localparam logic [2:0] LD_LW  = 3'd2;
   localparam logic [2:0] LD_LBU = 3'd4;
   localparam logic [2:0] LD_LHU = 3'd5;

   // Fixed datapath width used by the request bundle
   localparam int TC_XLEN = 32;

   // Retiring instruction as handed over by the memory stage
   typedef struct packed {
      logic                rf_wen;
      logic [4:0]          rd_addr;
      logic [1:0]          wb_src;
      logic [TC_XLEN-1:0]  alu_result;
      logic [TC_XLEN-1:0]  pc_incr;
      logic [2:0]          ld_funct3;
   } wb_req_t;

endpackage

// File: rtl/load_align.sv
// Aligns a loaded word by its byte offset and sign/zero extends it by load type.
module load_align
   import tcore_param::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_data,
   input  logic [1:0]      i_offset,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_data
);

   logic [XLEN-1:0] w_shifted;

   // Bring the addressed byte down to bit 0, then extend according to the load type
   always_comb begin
      w_shifted = i_data >> {i_offset, 3'b000};
      case (i_funct3)
         LD_LB:   o_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
         LD_LBU:  o_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
         LD_LH:   o_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
         LD_LHU:  o_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
         default: o_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/stage5_writeback.sv
// Writeback stage: selects the result source, waits on load responses,
// drives registered register-file writes/forwarding and counts retirements.
module stage5_writeback
   import tcore_param::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   input  logic              rf_wen_i,
   input  logic [4:0]        rd_addr_i,
   input  logic [1:0]        wb_src_i,
   input  logic [XLEN-1:0]   alu_result_i,
   input  logic [XLEN-1:0]   pc_incr_i,
   input  logic [2:0]        ld_funct3_i,
   input  logic              dmem_rvalid_i,
   input  logic [XLEN-1:0]   dmem_rdata_i,
   input  logic              dmem_err_i,
   output logic              stall_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic [4:0]        rd_addr_o,
   output logic              rf_rw_en_o,
   output logic              load_fault_o,
   output logic              retire_o,
   output logic [CNT_W-1:0]  instret_o
);

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_LD = 1'b1
   } state_e;

   state_e           r_state;
   state_e           w_nextState;

   logic [4:0]       r_ldRd;
   logic             r_ldWen;
   logic [2:0]       r_ldFunct3;
   logic [1:0]       r_ldOffset;

   logic [XLEN-1:0]  r_wbData;
   logic [4:0]       r_rdAddr;
   logic             r_rfWe;
   logic             r_loadFault;
   logic             r_retire;
   logic [CNT_W-1:0] r_instret;

   wb_req_t          w_req;
   logic             w_accept;
   logic             w_latchLoad;
   logic             w_we;
   logic             w_retire;
   logic             w_fault;
   logic [XLEN-1:0]  w_data;
   logic [4:0]       w_rd;
   logic [XLEN-1:0]  w_loadData;

   assign w_req = '{rf_wen:     rf_wen_i,
                    rd_addr:    rd_addr_i,
                    wb_src:     wb_src_i,
                    alu_result: alu_result_i,
                    pc_incr:    pc_incr_i,
                    ld_funct3:  ld_funct3_i};

   // Stall comes from the registered state only, never from the memory response
   assign stall_o  = (r_state == WAIT_LD);
   assign w_accept = valid_i && !stall_o;

   load_align #(.XLEN(XLEN)) u_loadAlign (
      .i_data   (dmem_rdata_i),
      .i_offset (r_ldOffset),
      .i_funct3 (r_ldFunct3),
      .o_data   (w_loadData)
   );

   // Next-state and next-output decode; write data/address only move on real writes
   always_comb begin
      w_nextState = r_state;
      w_latchLoad = 1'b0;
      w_we        = 1'b0;
      w_retire    = 1'b0;
      w_fault     = 1'b0;
      w_data      = r_wbData;
      w_rd        = r_rdAddr;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_req.wb_src == WB_LOAD) begin
                  w_latchLoad = 1'b1;
                  w_nextState = WAIT_LD;
               end else begin
                  w_we     = w_req.rf_wen && (w_req.rd_addr != 5'd0);
                  w_retire = 1'b1;
                  if (w_we) begin
                     w_data = (w_req.wb_src == WB_PC4) ? w_req.pc_incr : w_req.alu_result;
                     w_rd   = w_req.rd_addr;
                  end
               end
            end
         end
         WAIT_LD: begin
            if (dmem_rvalid_i) begin
               w_nextState = IDLE;
               if (dmem_err_i) begin
                  w_fault = 1'b1;
               end else begin
                  w_we     = r_ldWen && (r_ldRd != 5'd0);
                  w_retire = 1'b1;
                  if (w_we) begin
                     w_data = w_loadData;
                     w_rd   = r_ldRd;
                  end
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State register; reset abandons any outstanding load
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_nextState;
   end

   // Capture the load context so the response can be steered later
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ldRd     <= '0;
         r_ldWen    <= 1'b0;
         r_ldFunct3 <= '0;
         r_ldOffset <= '0;
      end else if (w_latchLoad) begin
         r_ldRd     <= w_req.rd_addr;
         r_ldWen    <= w_req.rf_wen;
         r_ldFunct3 <= w_req.ld_funct3;
         r_ldOffset <= w_req.alu_result[1:0];
      end
   end

   // Registered writeback outputs and the wrapping retirement counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wbData    <= '0;
         r_rdAddr    <= '0;
         r_rfWe      <= 1'b0;
         r_loadFault <= 1'b0;
         r_retire    <= 1'b0;
         r_instret   <= '0;
      end else begin
         r_wbData    <= w_data;
         r_rdAddr    <= w_rd;
         r_rfWe      <= w_we;
         r_loadFault <= w_fault;
         r_retire    <= w_retire;
         if (w_retire) r_instret <= r_instret + 1'b1;
      end
   end

   assign wb_data_o    = r_wbData;
   assign rd_addr_o    = r_rdAddr;
   assign rf_rw_en_o   = r_rfWe;
   assign load_fault_o = r_loadFault;
   assign retire_o     = r_retire;
   assign instret_o    = r_instret;

`ifndef SYNTHESIS
   // A load response with no load outstanding indicates a broken memory handshake
   property p_noStrayRvalid;
      @(posedge clk_i) disable iff (!rst_ni) !(r_state == IDLE && dmem_rvalid_i);
   endproperty
   a_noStrayRvalid: assert property (p_noStrayRvalid);
`endif

endmodule

// File: tb/tb_stage5_writeback.sv
// Directed testbench for stage5_writeback with hand-computed expectations.
module tb_stage5_writeback;

   localparam int XLEN  = 32;
   localparam int CNT_W = 8;

   logic              clk;
   logic              rstN;
   logic              validI;
   logic              rfWenI;
   logic [4:0]        rdAddrI;
   logic [1:0]        wbSrcI;
   logic [XLEN-1:0]   aluResultI;
   logic [XLEN-1:0]   pcIncrI;
   logic [2:0]        ldFunct3I;
   logic              rvalidI;
   logic [XLEN-1:0]   rdataI;
   logic              errI;
   logic              stallO;
   logic [XLEN-1:0]   wbDataO;
   logic [4:0]        rdAddrO;
   logic              rfWeO;
   logic              faultO;
   logic              retireO;
   logic [CNT_W-1:0]  instretO;

   int checks = 0;
   int errors = 0;

   stage5_writeback #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk_i         (clk),
      .rst_ni        (rstN),
      .valid_i       (validI),
      .rf_wen_i      (rfWenI),
      .rd_addr_i     (rdAddrI),
      .wb_src_i      (wbSrcI),
      .alu_result_i  (aluResultI),
      .pc_incr_i     (pcIncrI),
      .ld_funct3_i   (ldFunct3I),
      .dmem_rvalid_i (rvalidI),
      .dmem_rdata_i  (rdataI),
      .dmem_err_i    (errI),
      .stall_o       (stallO),
      .wb_data_o     (wbDataO),
      .rd_addr_o     (rdAddrO),
      .rf_rw_en_o    (rfWeO),
      .load_fault_o  (faultO),
      .retire_o      (retireO),
      .instret_o     (instretO)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic wen, input logic [4:0] rd,
                                input logic [1:0] src, input logic [31:0] alu,
                                input logic [31:0] pc, input logic [2:0] f3);
      validI     = v;
      rfWenI     = wen;
      rdAddrI    = rd;
      wbSrcI     = src;
      aluResultI = alu;
      pcIncrI    = pc;
      ldFunct3I  = f3;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full writeback check after a cycle
   task automatic checkWb(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] data, input logic ret, input logic [7:0] cnt);
      checkOutput({tag, ".we"},      64'(rfWeO),    64'(we));
      checkOutput({tag, ".rd"},      64'(rdAddrO),  64'(rd));
      checkOutput({tag, ".data"},    64'(wbDataO),  64'(data));
      checkOutput({tag, ".retire"},  64'(retireO),  64'(ret));
      checkOutput({tag, ".instret"}, 64'(instretO), 64'(cnt));
      checkOutput({tag, ".stall"},   64'(stallO),   64'd0);
   endtask

   // Issue a load with a one-cycle response and leave its result on the outputs
   task automatic doLoad(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                         input logic [31:0] rdata);
      applyStimulus(1'b1, 1'b1, rd, 2'd1, {30'h0, off}, 32'h0, f3);
      tick();
      checkOutput("load.stall", 64'(stallO), 64'd1);
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0);
      rvalidI = 1'b1;
      rdataI  = rdata;
      errI    = 1'b0;
      tick();
      rvalidI = 1'b0;
   endtask

   initial begin
      $display("[TB] start");
      rstN = 1'b0;
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0);
      rvalidI = 1'b0;
      rdataI  = '0;
      errI    = 1'b0;
      tick();
      tick();
      checkWb("reset", 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);
      checkOutput("reset.fault", 64'(faultO), 64'd0);
      rstN = 1'b1;
      tick();

      // ALU op, one-cycle latency
      applyStimulus(1'b1, 1'b1, 5'd5, 2'd0, 32'h1234_5678, 32'h0, 3'd0);
      tick();
      checkWb("alu", 1'b1, 5'd5, 32'h1234_5678, 1'b1, 8'd1);
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0);
      tick();
      checkWb("idle", 1'b0, 5'd5, 32'h1234_5678, 1'b0, 8'd1);

      // LB offset 3 with a three-cycle stall, next ALU instruction held upstream
      applyStimulus(1'b1, 1'b1, 5'd7, 2'd1, 32'h0000_0003, 32'h0, 3'd0);
      tick();
      checkOutput("lb.stall1", 64'(stallO), 64'd1);
      checkOutput("lb.noret", 64'(retireO), 64'd0);
      checkOutput("lb.nowe", 64'(rfWeO), 64'd0);
      applyStimulus(1'b1, 1'b1, 5'd9, 2'd0, 32'h0000_00AA, 32'h0, 3'd0);
      tick();
      checkOutput("lb.stall2", 64'(stallO), 64'd1);
      tick();
      checkOutput("lb.stall3", 64'(stallO), 64'd1);
      checkOutput("lb.instret", 64'(instretO), 64'd1);
      rvalidI = 1'b1;
      rdataI  = 32'h80FF_0000;
      tick();
      rvalidI = 1'b0;
      checkWb("lb", 1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 8'd2);
      tick();
      checkWb("afterlb", 1'b1, 5'd9, 32'h0000_00AA, 1'b1, 8'd3);
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0);

      // Alignment and extension
      doLoad(3'd5, 2'd2, 5'd10, 32'h8001_ABCD);
      checkWb("lhu", 1'b1, 5'd10, 32'h0000_8001, 1'b1, 8'd4);
      doLoad(3'd1, 2'd2, 5'd11, 32'h8001_ABCD);
      checkWb("lh", 1'b1, 5'd11, 32'hFFFF_8001, 1'b1, 8'd5);
      doLoad(3'd3, 2'd0, 5'd12, 32'h8001_ABCD);
      checkWb("f3ill", 1'b1, 5'd12, 32'h8001_ABCD, 1'b1, 8'd6);
      doLoad(3'd4, 2'd1, 5'd13, 32'h0000_F000);
      checkWb("lbu", 1'b1, 5'd13, 32'h0000_00F0, 1'b1, 8'd7);
      doLoad(3'd2, 2'd0, 5'd14, 32'hDEAD_BEEF);
      checkWb("lw", 1'b1, 5'd14, 32'hDEAD_BEEF, 1'b1, 8'd8);

      // Errored load response
      applyStimulus(1'b1, 1'b1, 5'd15, 2'd1, 32'h0, 32'h0, 3'd2);
      tick();
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0);
      rvalidI = 1'b1;
      errI    = 1'b1;
      rdataI  = 32'h5555_5555;
      tick();
      rvalidI = 1'b0;
      errI    = 1'b0;
      checkOutput("err.fault", 64'(faultO), 64'd1);
      checkWb("err", 1'b0, 5'd14, 32'hDEAD_BEEF, 1'b0, 8'd8);
      tick();
      checkOutput("err.pulse", 64'(faultO), 64'd0);

      // PC+4 source, source 3 as ALU, no-write and x0 retirements
      applyStimulus(1'b1, 1'b1, 5'd3, 2'd2, 32'h0000_0BAD, 32'h0000_1004, 3'd0);
      tick();
      checkWb("pc4", 1'b1, 5'd3, 32'h0000_1004, 1'b1, 8'd9);
      applyStimulus(1'b1, 1'b1, 5'd4, 2'd3, 32'hCAFE_0001, 32'h0000_2004, 3'd0);
      tick();
      checkWb("src3", 1'b1, 5'd4, 32'hCAFE_0001, 1'b1, 8'd10);
      applyStimulus(1'b1, 1'b0, 5'd6, 2'd0, 32'h1111_1111, 32'h0, 3'd0);
      tick();
      checkWb("nowen", 1'b0, 5'd4, 32'hCAFE_0001, 1'b1, 8'd11);
      applyStimulus(1'b1, 1'b1, 5'd0, 2'd0, 32'h2222_2222, 32'h0, 3'd0);
      tick();
      checkWb("x0", 1'b0, 5'd4, 32'hCAFE_0001, 1'b1, 8'd12);

      // Run the counter up to all-ones, then wrap
      applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0);
      for (int i = 0; i < 243; i++) tick();
      checkOutput("cnt.max", 64'(instretO), 64'hFF);
      tick();
      checkOutput("cnt.wrap", 64'(instretO), 64'h0);
      checkOutput("cnt.wrapret", 64'(retireO), 64'd1);
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0);
      tick();

      // Reset while a load is pending; the late response is ignored
      applyStimulus(1'b1, 1'b1, 5'd20, 2'd1, 32'h0, 32'h0, 3'd2);
      tick();
      checkOutput("rst.stallpre", 64'(stallO), 64'd1);
      applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0);
      rstN = 1'b0;
      #1;
      checkWb("rst.async", 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);
      rvalidI = 1'b1;
      rdataI  = 32'h7777_7777;
      tick();
      rvalidI = 1'b0;
      rstN    = 1'b1;
      tick();
      checkWb("rst.after", 1'b0, 5'd0, 32'h0, 1'b0, 8'd0);
      checkOutput("rst.fault", 64'(faultO), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
